instr_fetch_fifo: RTL

Dual-issue instruction queue between the cache/fetch unit and the two decode slots. It accepts up to two fetched instructions with their PCs per cycle and presents the two oldest to Instr_Decode1/Instr_Decode2. It raises `fifo_full` to the control unit, which turns it into `stop_fetch`. It obeys `fifo_rst` (registered flush) and `fifo_stall` (decode backpressure) from the control unit.

---
 rtl/instr_fetch_fifo.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_fifo.sv
// instr_fetch_fifo: dual-issue instruction queue between the fetch unit and
// the two decode slots. Accepts up to two {instr, pc} pairs per cycle and
// presents the two oldest entries to decode.
//
// Optional feature: define IFIFO_BYPASS_EN to let writes into an empty,
// unstalled queue reach the read lanes combinationally (zero latency).
// Without the macro there is no wr -> rd combinational path.
module instr_fetch_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_rst,
    input  logic        fifo_stall,
    input  logic [1:0]  wr_valid,
    input  logic [31:0] wr_instr0,
    input  logic [31:0] wr_instr1,
    input  logic [31:0] wr_pc0,
    input  logic [31:0] wr_pc1,
    output logic        fifo_full,
    output logic [1:0]  rd_valid,
    output logic [31:0] instr1,
    output logic [31:0] instr2,
    output logic [31:0] pc1,
    output logic [31:0] pc2,
    output logic        overflow
);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t mem_q [DEPTH];

    ptr_t   head_q, head_d;
    ptr_t   tail_q, tail_d;
    cnt_t   count_q, count_d;
    logic   overflow_q, overflow_d;

    entry_t push0, push1;      // compacted write slots (oldest first)
    entry_t lane0, lane1;      // read lanes before zeroing
    cnt_t   push_n, pop_n;
    logic   push_any;
    logic   push_ok;
    logic   bypass;

    // Full leaves one slot of headroom for the fetch already in flight
    assign fifo_full = (count_q > cnt_t'(DEPTH - 2));
    assign overflow  = overflow_q;

`ifdef IFIFO_BYPASS_EN
    assign bypass = rst_n && fifo_rst && !fifo_stall && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    // Compact the valid write slots: slot0 first, then slot1
    always_comb begin
        push_any    = |wr_valid;
        push_n      = cnt_t'(wr_valid[0]) + cnt_t'(wr_valid[1]);
        push0.instr = wr_valid[0] ? wr_instr0 : wr_instr1;
        push0.pc    = wr_valid[0] ? wr_pc0    : wr_pc1;
        push1.instr = wr_instr1;
        push1.pc    = wr_pc1;
        // Acceptance looks only at the start-of-cycle full flag
        push_ok     = push_any && !fifo_full && fifo_rst && !bypass;
    end

    // Present the two oldest entries (or bypassed slots); idle lanes read 0
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        rd_valid = {count_q >= cnt_t'(2), count_q != '0};
        lane0    = mem_q[head_q];
        lane1    = mem_q[head_q + ptr_t'(1)];
`ifdef IFIFO_BYPASS_EN
        if (bypass) begin
            rd_valid = {wr_valid == 2'b11, push_any};
            lane0    = push0;
            lane1    = push1;
        end
`endif
        instr1 = rd_valid[0] ? lane0.instr : '0;
        pc1    = rd_valid[0] ? lane0.pc    : '0;
        instr2 = rd_valid[1] ? lane1.instr : '0;
        pc2    = rd_valid[1] ? lane1.pc    : '0;
        pop_n  = fifo_stall ? '0 : (cnt_t'(rd_valid[0]) + cnt_t'(rd_valid[1]));
    end

    // Next pointers, count and sticky overflow; flush overrides everything
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (!fifo_rst) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (!bypass) begin
            if (push_ok) begin
                tail_d = tail_q + ptr_t'(push_n);
            end
            if (push_any && fifo_full) begin
                overflow_d = 1'b1;
            end
            head_d  = head_q + ptr_t'(pop_n);
            count_d = count_q + (push_ok ? push_n : cnt_t'(0)) - pop_n;
        end
    end

    // Entry storage: written only by accepted pushes
    // NOTE: the array has no reset; validity comes from count, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= push0;
            if (push_n == cnt_t'(2)) begin
                mem_q[tail_q + ptr_t'(1)] <= push1;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
